// File: rtl/uart_receiver_if.sv
// Byte-delivery side of the UART receiver: a valid/ready handshake
// carrying one received byte, plus the single-cycle error strobes.
// The receiver uses the master modport and the consumer uses the slave modport.
interface uart_receiver_if;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready;
   logic       framing_error;
   logic       overrun;

   modport master (
      output data_out,
      output data_out_valid,
      output framing_error,
      output overrun,
      input  data_out_ready
   );

   modport slave (
      input  data_out,
      input  data_out_valid,
      input  framing_error,
      input  overrun,
      output data_out_ready
   );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a 2-flop line synchronizer, mid-bit sampling,
// false-start rejection and stop-bit checking. A one-byte output buffer
// feeds a valid/ready consumer. Framing errors and overruns are reported
// as single-cycle pulses.
module uart_receiver #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            serial_in,
   uart_receiver_if.master rx_bus
);

   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
   localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

   localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [1:0]       sync;
   logic             rx;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_index;
   logic [7:0]       shift;
   logic             tick;
   logic             deliver;
   logic             frame_bad;
   logic             handshake;

   logic [7:0]       data_q;
   logic             valid_q;
   logic             framing_q;
   logic             overrun_q;

   // Two-flop synchronizer; both flops reset high so the line looks idle
   // and leaving reset can never fake a start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync <= 2'b11;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values and the chain shifts by exactly one stage.
         sync <= {sync[0], serial_in};
      end
   end

   assign rx = sync[1];

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Sample point: half a bit after the start edge, then one full bit apart.
   assign tick = (state == START) ? (cnt == SAMPLE_LAST) : (cnt == SYMBOL_LAST);

   // FSM next-state logic.
   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = state;
      unique case (state)
         IDLE:      if (!rx) state_next = START;
         START:     if (tick) state_next = rx ? IDLE : DATA;
         DATA:      if (tick && bit_index == 3'd7) state_next = STOP;
         STOP:      if (tick) state_next = rx ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (rx) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // FSM output decode: stop-bit outcome strobes for the buffer logic.
   always_comb begin
      deliver   = 1'b0;
      frame_bad = 1'b0;
      if (state == STOP && tick) begin
         deliver   = rx;
         frame_bad = !rx;
      end
   end

   // Bit timer, bit index and shift register; the timer is cleared at every
   // sample point, so it never runs past SYMBOL_EDGE_TIME-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         bit_index <= 3'd0;
         shift     <= 8'h00;
      end else begin
         unique case (state)
            START: begin
               cnt       <= tick ? '0 : cnt + 1'b1;
               bit_index <= 3'd0;
            end
            DATA: begin
               cnt <= tick ? '0 : cnt + 1'b1;
               if (tick) begin
                  shift[bit_index] <= rx;
                  bit_index        <= bit_index + 3'd1;
               end
            end
            STOP: begin
               cnt <= tick ? '0 : cnt + 1'b1;
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

   assign handshake = valid_q && rx_bus.data_out_ready;

   // One-byte output buffer and registered error pulses. A delivery that
   // coincides with a handshake replaces the byte without an overrun.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         framing_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         framing_q <= frame_bad;
         overrun_q <= deliver && valid_q && !handshake;
         if (deliver && (!valid_q || handshake)) begin
            data_q  <= shift;
            valid_q <= 1'b1;
         end else if (handshake) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx_bus.data_out       = data_q;
   assign rx_bus.data_out_valid = valid_q;
   assign rx_bus.framing_error  = framing_q;
   assign rx_bus.overrun        = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 50 MHz / 115200 baud. Bytes that
// should reach the consumer are pushed to a queue when their frame is sent,
// and they are popped and compared on every handshake.
module tb_uart_receiver;

   localparam int BIT_T = 434;
   localparam int LAT   = 4125;

   logic clk       = 1'b0;
   logic rst       = 1'b0;
   logic serial_in = 1'b1;

   uart_receiver_if bus ();

   uart_receiver #(
      .CLOCK_FREQ(50_000_000),
      .BAUD_RATE (115_200)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .serial_in(serial_in),
      .rx_bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         errors  = 0;
   int         checks  = 0;
   int         fe_cnt  = 0;
   int         ovr_cnt = 0;
   int         pop_cnt = 0;
   int         last_fall = 0;
   bit         auto_ready = 1'b0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Monitor, sampling just after the falling edge: counts strobes and
   // scores every handshake against the queue.
   always @(negedge clk) begin
      #1;
      if (bus.framing_error) fe_cnt++;
      if (bus.overrun) ovr_cnt++;
      if (bus.data_out_valid && bus.data_out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_extra_byte", exp_q.size(), 1);
         end else begin
            check("sb_byte", bus.data_out, exp_q.pop_front());
            pop_cnt++;
         end
      end
   end

   // Auto consumer: a one-cycle ready pulse on each valid byte.
   always @(negedge clk) begin
      if (auto_ready) bus.data_out_ready = bus.data_out_valid && !bus.data_out_ready;
   end

   // Drives one frame. rst_bit >= 0 asserts reset in the middle of that data
   // bit and holds it until the line is back to idle.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_bit);
      @(negedge clk);
      last_fall = cyc;
      serial_in = 1'b0;
      repeat (BIT_T) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         serial_in = b[i];
         if (i == rst_bit) begin
            repeat (BIT_T / 2) @(negedge clk);
            rst = 1'b0;
            repeat (BIT_T - BIT_T / 2) @(negedge clk);
         end else begin
            repeat (BIT_T) @(negedge clk);
         end
      end
      serial_in = stop_bit;
      repeat (BIT_T) @(negedge clk);
      serial_in = 1'b1;
      if (!rst) begin
         repeat (5) @(negedge clk);
         rst = 1'b1;
      end
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!bus.data_out_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!bus.data_out_valid) check("valid_timeout", bus.data_out_valid, 1);
   endtask

   task automatic pulse_ready();
      bus.data_out_ready = 1'b1;
      @(negedge clk);
      bus.data_out_ready = 1'b0;
   endtask

   int  lat;
   int  base_fe;
   int  base_ovr;
   int  base_pop;
   bit  seen_valid;
   bit  stable;

   initial begin
      bus.data_out_ready = 1'b0;

      // Reset held for 10 cycles with the line toggling.
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         serial_in = ~serial_in;
         if (i == 5) begin
            check("rst_data", bus.data_out, 8'h00);
            check("rst_valid", bus.data_out_valid, 0);
            check("rst_fe", bus.framing_error, 0);
            check("rst_ovr", bus.overrun, 0);
         end
      end
      serial_in = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      seen_valid = 1'b0;
      repeat (5000) begin
         @(negedge clk);
         if (bus.data_out_valid) seen_valid = 1'b1;
      end
      check("idle_no_valid", seen_valid, 0);
      check("idle_no_err", fe_cnt + ovr_cnt, 0);

      // Single byte with ready low: latency, data and hold.
      exp_q.push_back(8'hA5);
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1, -1);
         begin
            @(negedge clk);
            wait_valid(5000);
            lat = cyc - last_fall;
            check("a5_latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
            check("a5_data", bus.data_out, 8'hA5);
            stable = 1'b1;
            repeat (50) begin
               @(negedge clk);
               if (!bus.data_out_valid || bus.data_out !== 8'hA5) stable = 1'b0;
            end
            check("a5_held", stable, 1);
            pulse_ready();
            check("a5_valid_cleared", bus.data_out_valid, 0);
         end
      join
      check("a5_popped", pop_cnt, 1);

      // Back-to-back frames with one-cycle ready pulses.
      base_fe  = fe_cnt;
      base_ovr = ovr_cnt;
      base_pop = pop_cnt;
      auto_ready = 1'b1;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h3C);
      send_frame(8'h00, 1'b1, -1);
      send_frame(8'hFF, 1'b1, -1);
      send_frame(8'h3C, 1'b1, -1);
      repeat (20) @(negedge clk);
      auto_ready = 1'b0;
      bus.data_out_ready = 1'b0;
      check("b2b_handshakes", pop_cnt - base_pop, 3);
      check("b2b_no_errors", (fe_cnt - base_fe) + (ovr_cnt - base_ovr), 0);

      // Overrun: second byte dropped while the first is still held.
      base_ovr = ovr_cnt;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, -1);
      send_frame(8'h22, 1'b1, -1);
      repeat (10) @(negedge clk);
      check("ovr_pulse", ovr_cnt - base_ovr, 1);
      check("ovr_kept_data", bus.data_out, 8'h11);
      check("ovr_kept_valid", bus.data_out_valid, 1);

      // Handshake in the same cycle as the third byte completes.
      exp_q.push_back(8'h33);
      fork
         send_frame(8'h33, 1'b1, -1);
         begin
            @(negedge clk);
            repeat (lat - 1) @(negedge clk);
            pulse_ready();
            check("same_cycle_valid", bus.data_out_valid, 1);
            check("same_cycle_data", bus.data_out, 8'h33);
         end
      join
      check("same_cycle_no_ovr", ovr_cnt - base_ovr, 1);
      pulse_ready();
      check("ovr_queue_empty", exp_q.size(), 0);

      // Short low glitch: rejected silently.
      base_fe = fe_cnt;
      @(negedge clk);
      serial_in = 1'b0;
      repeat (100) @(negedge clk);
      serial_in = 1'b1;
      repeat (1000) @(negedge clk);
      check("glitch_no_valid", bus.data_out_valid, 0);
      check("glitch_no_fe", fe_cnt - base_fe, 0);

      // Stop bit sampled low.
      send_frame(8'h55, 1'b0, -1);
      repeat (50) @(negedge clk);
      check("frame_fe_once", fe_cnt - base_fe, 1);
      check("frame_no_valid", bus.data_out_valid, 0);

      // Break: line low for 20 bit times, then a good byte.
      base_fe = fe_cnt;
      @(negedge clk);
      serial_in = 1'b0;
      repeat (20 * BIT_T) @(negedge clk);
      serial_in = 1'b1;
      repeat (50) @(negedge clk);
      check("break_fe_once", fe_cnt - base_fe, 1);
      check("break_no_valid", bus.data_out_valid, 0);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, -1);
      wait_valid(100);
      check("after_break_data", bus.data_out, 8'h5A);
      pulse_ready();
      check("after_break_empty", exp_q.size(), 0);

      // Reset in the middle of bit 4 of 8'hC3, then 8'h7E.
      base_fe  = fe_cnt;
      base_ovr = ovr_cnt;
      send_frame(8'hC3, 1'b1, 4);
      repeat (20) @(negedge clk);
      check("rst_mid_no_valid", bus.data_out_valid, 0);
      exp_q.push_back(8'h7E);
      send_frame(8'h7E, 1'b1, -1);
      wait_valid(100);
      check("rst_mid_data", bus.data_out, 8'h7E);
      pulse_ready();
      check("rst_mid_no_pulses", (fe_cnt - base_fe) + (ovr_cnt - base_ovr), 0);
      check("final_queue_empty", exp_q.size(), 0);
      check("total_handshakes", pop_cnt, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel 8N1 UART receiver sitting directly upstream of the CPU's memory-mapped UART data register. It turns the `serial_in` line into bytes, with line synchronization, mid-bit sampling, false-start rejection and stop-bit checking. Received bytes go to the CPU over a valid/ready handshake with one byte of buffering. Framing and overrun events are reported as single-cycle pulses.

## Interface

- `CLOCK_FREQ`, 50_000_000, system clock in Hz.
- `BAUD_RATE`, 115_200, line rate in bits/s.
- Derived `SYMBOL_EDGE_TIME` = CLOCK_FREQ / BAUD_RATE, using integer division (434 at the defaults).
- Derived `SAMPLE_TIME` = SYMBOL_EDGE_TIME / 2, using integer division (217).

Ports:

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0), released synchronously by the parent.
- `serial_in`  in  1  asynchronous UART line; idle is 1.
- `data_out`  out  8  received byte; held stable while `data_out_valid` is 1.
- `data_out_valid`  out  1  a byte is available.
- `data_out_ready`  in  1  the consumer accepts the byte this cycle.
- `framing_error`  out  1  one-cycle pulse when the stop bit sampled 0.
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped because the buffer is full.

## Operation

- `serial_in` passes through a 2-flop synchronizer, giving `rx`. Both flops reset to 1 so a reset cannot create a false start.
- States and transitions:
  - **IDLE**: `rx` == 0 goes to START with the counter cleared.
  - **START**: the counter runs to SAMPLE_TIME-1, then `rx` is sampled. If it reads 1 (glitch), go back to IDLE with nothing reported. If it reads 0, go to DATA with the counter and bit index cleared.
  - **DATA**: every SYMBOL_EDGE_TIME cycles, sample `rx` into shift[bit_index], LSB first. After bit 7, go to STOP.
  - **STOP**: after SYMBOL_EDGE_TIME cycles, sample `rx`.
    - 1: deliver the byte (see buffer rules), then go to IDLE.
    - 0: pulse `framing_error`, discard the byte, go to WAIT_HIGH.
  - **WAIT_HIGH**: stay until `rx` == 1, then go to IDLE. This covers break conditions: a held-low line produces exactly one `framing_error` and nothing else.
- Because every sample point is relative to the detected start edge, each sample lands at mid-bit.
- Counter width is clog2(SYMBOL_EDGE_TIME). The bit index is 3 bits. The counter never wraps beyond SYMBOL_EDGE_TIME-1.
- Buffer rules (one byte of storage, `data_out` register):
  - Handshake occurs when `data_out_valid` && `data_out_ready`; `data_out_valid` clears on the next edge.
  - On delivery with `data_out_valid` == 0, load `data_out` and set valid.
  - On delivery in the same cycle as a handshake, load the new byte and keep valid at 1; no overrun.
  - On delivery with valid == 1 and no handshake, keep the old byte, drop the new one, and pulse `overrun`.
- `data_out_ready` while valid == 0 has no effect.
- Reset mid-frame: everything returns to IDLE immediately. The partial byte is lost and the buffer empties. No pulse is generated on reset or on release.

## Timing

- Values during and after reset:
  - `data_out` = 8'h00.
  - `data_out_valid` = 0.
  - `framing_error` = 0.
  - `overrun` = 0.
  - FSM = IDLE.
  - Synchronizer = 2'b11.
- Start detection occurs 2 cycles after the `serial_in` fall (synchronizer latency).
- Latency: `data_out_valid` rises 2 + SAMPLE_TIME + 9·SYMBOL_EDGE_TIME cycles (±1) after the start-bit falling edge on `serial_in`. At the defaults that is 2 + 217 + 3906 = 4125 cycles.
- `framing_error` and `overrun` are high for exactly one cycle, on the edge where the stop bit is sampled.
- The receiver is back in IDLE on the cycle after a good stop sample. A back-to-back frame whose start edge arrives half a bit after the stop-bit sample point is received correctly.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- **Reset:** hold `rst`=0 for 10 cycles with `serial_in` toggling. Required: all outputs 0, and no valid after release with the line idle for 5000 cycles.
- **Single byte:** send 8'hA5 at the default parameters with `data_out_ready`=0. Required: `data_out_valid` rises 4125±1 cycles after the start edge, `data_out`=8'hA5, and it is held until `data_out_ready` is pulsed, after which valid is 0 on the next cycle.
- **Back-to-back:** send 8'h00, 8'hFF, 8'h3C with 1-cycle ready pulses on each valid. Required: three handshakes in order, no error pulses.
- **Overrun:** send 8'h11 then 8'h22 with ready held 0. Required: `data_out` stays 8'h11 and `overrun` pulses once at the second stop sample. Then assert ready with a handshake landing in the same cycle as a third byte 8'h33 completing. Required: `data_out`=8'h33, valid stays 1, no overrun.
- **Glitch and framing:**
  - A 100-cycle low glitch produces no valid and no error.
  - A frame with stop bit 0 produces one `framing_error` pulse and no valid.
  - A line held low for 20 bit times produces exactly one `framing_error`; a following good byte 8'h5A is then received correctly.
- **Reset mid-frame:** assert `rst` during bit 4 of 8'hC3, release, then send 8'h7E. Required: only 8'h7E is delivered.
